risc_lsu: RTL and testbench
===========================

// Module: risc_lsu
// PURPOSE
//  RV32I load/store unit sitting between the execute stage and data memory. Accepts one
//  load/store per handshake and issues a single word-aligned request on a req/gnt/rvalid bus.
//  Returns extended load data or a store completion, with misalignment, illegal-size and
//  timeout errors. One transaction in flight; the pipeline stalls on !req_ready.
// PARAMETERS
//  XLEN        32  data/address width (only 32 supported)
//  MEM_TIMEOUT 64  cycles in REQ+WAIT before abort with timeout error (>=2)
// PORTS
//  clk           in   1     clock; all flops rising edge
//  rst_n         in   1     reset, asynchronous, active-low
//  req_valid     in   1     execute stage presents a memory op
//  req_ready     out  1     LSU idle, accepts op this cycle
//  req_we        in   1     1=store, 0=load
//  req_funct3    in   3     LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
//  req_addr      in   32    byte address (rs1+imm)
//  req_wdata     in   32    store data (rs2)
//  req_rd        in   5     load destination register
//  mem_req       out  1     memory request, held until mem_gnt
//  mem_we        out  1     memory write enable
//  mem_addr      out  32    word address, {req_addr[31:2],2'b00}
//  mem_wdata     out  32    lane-replicated store data
//  mem_be        out  4     byte enables
//  mem_gnt       in   1     request accepted this cycle
//  mem_rvalid    in   1     read data valid
//  mem_rdata     in   32    read data word
//  rsp_valid     out  1     one-cycle completion pulse, no backpressure
//  rsp_rdata     out  32    extended load data; 0 for stores and errors
//  rsp_rd        out  5     writeback register; 0 for stores and errors
//  rsp_err       out  1     completion is an error
//  rsp_err_code  out  2     0 none, 1 misaligned, 2 illegal funct3, 3 timeout
// BEHAVIOUR
//  States: IDLE, REQ, WAIT, RESP. Reset value: IDLE; all registered outputs 0; req_ready=1.
//  req_ready = (state==IDLE). Accept = req_valid && req_ready; latch all req_* fields.
//  IDLE->RESP on accept if illegal funct3 (011,110,111, or 1xx with req_we): code 2.
//   Otherwise, if misaligned (half: addr[0]!=0; word: addr[1:0]!=0): code 1.
//   Error responses produce no mem_req.
//  IDLE->REQ on a legal accept. mem_req=1 with mem_we/addr/wdata/be stable until gnt.
//  REQ: on mem_gnt, a store goes to RESP (completes at grant) and a load goes to WAIT.
//  WAIT: on mem_rvalid go to RESP. Select lane by addr[1:0]:
//   LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
//  Timeout counter clears on accept and counts each cycle in REQ or WAIT.
//   Reaching MEM_TIMEOUT goes to RESP with code 3; mem_req drops the same cycle.
//  RESP: rsp_valid=1 for exactly one cycle, then IDLE. A new accept is possible the next cycle.
//  Store lanes:
//   SB: wdata={4{b}}, be=4'b0001<<addr[1:0]
//   SH: wdata={2{h}}, be=addr[1]?1100:0011
//   SW: be=1111
//  mem_rvalid is ignored outside WAIT, so late data after a timeout is dropped.
//  mem_gnt coincident with timeout expiry: the grant wins.
//  rvalid in the same cycle as gnt is not legal; the next cycle is the earliest.
//  Async reset mid-transaction forces IDLE and zeroes outputs immediately.
//   The aborted op produces no response.
//  Min latency, load with immediate gnt and next-cycle rvalid: accept c0, REQ c1, WAIT c2, rsp_valid c3.
//  Min latency, store: rsp_valid at c2. Error responses: rsp_valid at c1.
// TESTING
//  1 LB addr 0x103, mem_rdata 0x80FF_0000 -> mem_addr 0x100, be 0, rsp_rdata 0xFFFF_FF80
//    at c3; repeat as LBU -> 0x0000_0080.
//  2 SH addr 0x202, wdata 0x1234_ABCD -> mem_addr 0x200, be 1100, mem_wdata 0xABCD_ABCD,
//    rsp_valid the cycle after gnt, rsp_rd 0.
//  3 LW addr 0x101 -> no mem_req, rsp_valid c1, err 1, code 1; funct3 011 -> code 2.
//  4 gnt delayed 5 cycles -> mem_req and mem_addr held stable; LHU addr 0x2, rdata 0x8001_0000
//    -> 0x0000_8001.
//  5 MEM_TIMEOUT 8, gnt but no rvalid -> code 3 at the 8th counted cycle; rvalid 2 cycles later ignored.
//  6 rst_n low in WAIT -> outputs 0 at once, no rsp_valid; next LW 0x40 completes normally.

Source files
------------

// File: rtl/risc_lsu.sv
// risc_lsu: RV32I load/store unit bridging execute to a req/gnt/rvalid data memory bus.
// One transaction in flight; errors answer without touching memory.
module risc_lsu #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic [4:0]      rsp_rd,
    output logic            rsp_err,
    output logic [1:0]      rsp_err_code
);
    localparam int CW = $clog2(MEM_TIMEOUT + 2);
    localparam logic [CW-1:0] TLAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state, state_n;

    logic            we_q;
    logic [2:0]      f3_q;
    logic [1:0]      addr_q;
    logic [4:0]      rd_q;
    logic [1:0]      code_q;
    logic [XLEN-1:0] rdata_q;
    logic [CW-1:0]   cnt;
    logic            accept, illegal, misaligned, expire, to_hit;
    logic [XLEN-1:0] st_data, lane, ld_data;
    logic [3:0]      st_be;

    assign accept     = req_valid && state == IDLE;
    assign illegal    = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_funct3[2] && req_we);
    assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign expire     = cnt >= TLAST;
    // A grant or read data in the expiring cycle takes priority over the timeout
    assign to_hit     = expire && ((state == REQ && !mem_gnt) || (state == WAIT && !mem_rvalid));

    assign st_data = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                     req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    assign st_be   = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
                     req_funct3[1:0] == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign lane    = mem_rdata >> {addr_q, 3'b000};
    assign ld_data = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]} :
                     f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]} : lane;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = accept ? ((illegal || misaligned) ? RESP : REQ) : IDLE;
            REQ:  state_n = mem_gnt ? (we_q ? RESP : WAIT) : (expire ? RESP : REQ);
            WAIT: state_n = (mem_rvalid || expire) ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            rd_q      <= '0;
            code_q    <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                we_q      <= req_we;
                f3_q      <= req_funct3;
                addr_q    <= req_addr[1:0];
                rd_q      <= req_rd;
                code_q    <= illegal ? 2'd2 : misaligned ? 2'd1 : 2'd0;
                rdata_q   <= '0;
                cnt       <= '0;
                mem_we    <= req_we;
                mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                mem_wdata <= req_we ? st_data : '0;
                mem_be    <= req_we ? st_be : '0;
            end
            if (state == REQ || state == WAIT)
                cnt <= cnt + CW'(1);
            if (to_hit)
                code_q <= 2'd3;
            if (state == WAIT && mem_rvalid)
                rdata_q <= ld_data;
        end
    end

    assign req_ready    = state == IDLE;
    assign mem_req      = state == REQ;
    assign rsp_valid    = state == RESP;
    assign rsp_err      = rsp_valid && code_q != 2'd0;
    assign rsp_err_code = rsp_valid ? code_q : 2'd0;
    assign rsp_rdata    = (rsp_valid && code_q == 2'd0) ? rdata_q : '0;
    assign rsp_rd       = (rsp_valid && code_q == 2'd0 && !we_q) ? rd_q : 5'd0;
endmodule

// File: tb/tb_risc_lsu.sv
// tb_risc_lsu: table, random and corner-sequence checks of risc_lsu against a byte-level model.
module tb_risc_lsu;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_be;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic [1:0]  rsp_err_code;

    int n_cmp = 0, n_bad = 0;

    risc_lsu #(.XLEN(32), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err), .rsp_err_code(rsp_err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic we; logic [2:0] f3; logic [31:0] addr, wdata, rdata; logic [4:0] rd;
        int gd, rvd;
        logic [31:0] e_rdata; logic [4:0] e_rd; logic [1:0] e_code;
        logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_wdata; int e_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata; logic [4:0] rd; logic err; logic [1:0] code; int lat;
        logic seen, mwe, stable; logic [31:0] maddr, wdata; logic [3:0] be;
    } res_t;

    // Memory responder: grant after gd cycles of mem_req, read data rvd cycles after a load grant
    int gd = 0, rvd = 0, rq_cnt = 0, rv_cnt = 0;
    bit rv_pend = 0;
    always @(negedge clk) begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (!rst_n) begin
            rv_pend = 0;
            rq_cnt = 0;
        end else if (mem_req) begin
            if (rq_cnt >= gd) begin
                mem_gnt = 1'b1;
                rq_cnt = 0;
                rv_pend = !mem_we;
                rv_cnt = 0;
            end else rq_cnt++;
        end else begin
            rq_cnt = 0;
            if (rv_pend) begin
                if (rv_cnt >= rvd) begin
                    mem_rvalid = 1'b1;
                    rv_pend = 0;
                end else rv_cnt++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
            input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] rd, input int g,
            input int r, input logic [31:0] e_rdata, input logic [4:0] e_rd, input logic [1:0] e_code,
            input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata, input int e_lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rd = rd;
        v.gd = g; v.rvd = r; v.e_rdata = e_rdata; v.e_rd = e_rd; v.e_code = e_code;
        v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_lat = e_lat;
        return v;
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        logic [7:0] b[4];
        logic signed [31:0] s;
        int size = 1 << v.f3[1:0];
        int off = int'(v.addr[1:0]);
        for (int i = 0; i < 4; i++) b[i] = v.rdata[8*i +: 8];
        e.e_code = (v.f3 inside {3'd3, 3'd6, 3'd7} || (v.we && v.f3[2])) ? 2'd2 :
                   (off % size != 0) ? 2'd1 : 2'd0;
        e.e_addr = v.addr & 32'hFFFF_FFFC;
        e.e_be = '0; e.e_wdata = '0; e.e_rdata = '0;
        if (v.we) begin
            for (int i = 0; i < 4; i++) begin
                e.e_be[i] = (i >= off && i < off + size);
                e.e_wdata[8*i +: 8] = v.wdata[8*(i % size) +: 8];
            end
        end else if (size == 1) begin
            s = $signed(b[off]);
            e.e_rdata = v.f3[2] ? {24'd0, b[off]} : s;
        end else if (size == 2) begin
            s = $signed({b[off+1], b[off]});
            e.e_rdata = v.f3[2] ? {16'd0, b[off+1], b[off]} : s;
        end else e.e_rdata = v.rdata;
        if (e.e_code != 0) e.e_rdata = '0;
        e.e_rd = (e.e_code == 0 && !v.we) ? v.rd : 5'd0;
        e.e_lat = e.e_code != 0 ? 1 : v.we ? v.gd + 2 : v.gd + v.rvd + 3;
        return e;
    endfunction

    task automatic run_op(input vec_t v, output res_t r);
        int cyc = 1;
        r = '{default: 0};
        r.stable = 1'b1;
        r.lat = -1;
        gd = v.gd; rvd = v.rvd; mem_rdata = v.rdata;
        @(negedge clk);
        chk("ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
        @(negedge clk);
        req_valid = 1'b0;
        while (cyc < 100) begin
            if (mem_req) begin
                if (!r.seen) begin
                    r.seen = 1'b1; r.maddr = mem_addr; r.be = mem_be;
                    r.wdata = mem_wdata; r.mwe = mem_we;
                end else if (mem_addr !== r.maddr || mem_be !== r.be ||
                             mem_wdata !== r.wdata || mem_we !== r.mwe) r.stable = 1'b0;
            end
            if (rsp_valid) begin
                r.lat = cyc; r.rdata = rsp_rdata; r.rd = rsp_rd;
                r.err = rsp_err; r.code = rsp_err_code;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        chk("pulse", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic check(input string tag, input vec_t e, input res_t r);
        chk({tag, " lat"}, r.lat, e.e_lat);
        chk({tag, " rdata"}, r.rdata, e.e_rdata);
        chk({tag, " rd"}, {27'd0, r.rd}, {27'd0, e.e_rd});
        chk({tag, " err"}, {31'd0, r.err}, {31'd0, e.e_code != 2'd0});
        chk({tag, " code"}, {30'd0, r.code}, {30'd0, e.e_code});
        if (e.e_code == 2'd1 || e.e_code == 2'd2)
            chk({tag, " no_req"}, {31'd0, r.seen}, 32'd0);
        else begin
            chk({tag, " addr"}, r.maddr, e.e_addr);
            chk({tag, " be"}, {28'd0, r.be}, {28'd0, e.e_be});
            chk({tag, " wdata"}, r.wdata, e.e_wdata);
            chk({tag, " we"}, {31'd0, r.mwe}, {31'd0, e.we});
            chk({tag, " stable"}, {31'd0, r.stable}, 32'd1);
        end
    endtask

    initial begin
        vec_t tbl[13];
        vec_t v, e;
        res_t r;
        logic [2:0] pool[5];
        pool[0] = 3'd0; pool[1] = 3'd1; pool[2] = 3'd2; pool[3] = 3'd4; pool[4] = 3'd5;
        //            we f3  addr      wdata         rdata         rd g  r  e_rdata       e_rd c  e_addr    be       e_wdata       lat
        tbl[0]  = mk(0, 0, 32'h103, 32'h0,         32'h80FF_0000, 1, 0, 0, 32'hFFFF_FF80, 1, 0, 32'h100, 4'b0000, 32'h0,         3);
        tbl[1]  = mk(0, 4, 32'h103, 32'h0,         32'h80FF_0000, 2, 0, 0, 32'h0000_0080, 2, 0, 32'h100, 4'b0000, 32'h0,         3);
        tbl[2]  = mk(1, 1, 32'h202, 32'h1234_ABCD, 32'h0,         3, 0, 0, 32'h0,         0, 0, 32'h200, 4'b1100, 32'hABCD_ABCD, 2);
        tbl[3]  = mk(0, 2, 32'h101, 32'h0,         32'h0,         4, 0, 0, 32'h0,         0, 1, 32'h0,   4'b0000, 32'h0,         1);
        tbl[4]  = mk(0, 3, 32'h100, 32'h0,         32'h0,         4, 0, 0, 32'h0,         0, 2, 32'h0,   4'b0000, 32'h0,         1);
        tbl[5]  = mk(0, 5, 32'h2,   32'h0,         32'h8001_0000, 6, 5, 0, 32'h0000_8001, 6, 0, 32'h0,   4'b0000, 32'h0,         8);
        tbl[6]  = mk(1, 0, 32'h7,   32'h0000_0055, 32'h0,         7, 0, 0, 32'h0,         0, 0, 32'h4,   4'b1000, 32'h5555_5555, 2);
        tbl[7]  = mk(1, 2, 32'h10,  32'hCAFE_F00D, 32'h0,         8, 7, 0, 32'h0,         0, 0, 32'h10,  4'b1111, 32'hCAFE_F00D, 9);
        tbl[8]  = mk(0, 1, 32'h6,   32'h0,         32'h9ABC_0000, 9, 1, 2, 32'hFFFF_9ABC, 9, 0, 32'h4,   4'b0000, 32'h0,         6);
        tbl[9]  = mk(1, 4, 32'h0,   32'h0,         32'h0,         1, 0, 0, 32'h0,         0, 2, 32'h0,   4'b0000, 32'h0,         1);
        tbl[10] = mk(1, 1, 32'h3,   32'h0,         32'h0,         1, 0, 0, 32'h0,         0, 1, 32'h0,   4'b0000, 32'h0,         1);
        tbl[11] = mk(0, 2, 32'h40,  32'h0,         32'hDEAD_BEEF, 31, 0, 0, 32'hDEAD_BEEF, 31, 0, 32'h40, 4'b0000, 32'h0,        3);
        tbl[12] = mk(0, 0, 32'h1,   32'h0,         32'h0000_7F00, 4, 0, 0, 32'h0000_007F, 4, 0, 32'h0,   4'b0000, 32'h0,         3);

        repeat (2) @(negedge clk);
        chk("rst ready", {31'd0, req_ready}, 32'd1);
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i], r);
            check($sformatf("tbl%0d", i), tbl[i], r);
        end

        for (int i = 0; i < 40; i++) begin
            v = mk($urandom_range(0, 1), ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) :
                   pool[$urandom_range(0, 4)], $urandom, $urandom, $urandom, 5'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, 0, 0, 0, 0);
            e = model(v);
            run_op(v, r);
            check($sformatf("rnd%0d", i), e, r);
        end

        // Load granted but never answered; read data arrives two cycles after the timeout
        v = mk(0, 2, 32'h80, 32'h0, 32'h1111_1111, 5, 0, 9, 32'h0, 0, 3, 32'h80, 4'b0000, 32'h0, 9);
        run_op(v, r);
        check("timeout_ld", v, r);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late rvalid", {31'd0, rsp_valid}, 32'd0);
        end
        // Store never granted
        v = mk(1, 2, 32'h84, 32'h7777_8888, 32'h0, 5, 50, 0, 32'h0, 0, 3, 32'h84, 4'b1111, 32'h7777_8888, 9);
        run_op(v, r);
        check("timeout_st", v, r);

        // Reset while a load waits for data
        gd = 0; rvd = 50;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h44; req_rd = 5'd3;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst mem_addr", mem_addr, 32'd0);
        chk("arst ready", {31'd0, req_ready}, 32'd1);
        chk("arst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("arst no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        v = mk(0, 2, 32'h40, 32'h0, 32'h0BAD_F00D, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = model(v);
        run_op(v, r);
        check("post_rst", e, r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
